// File: rtl/lcm_serial_writer.sv
// Serial write engine for the LCM panel: shifts one WIDTH-bit word MSB-first over CSN/SCL/SDA.
// One bus half-period lasts div_base+1 clk_in cycles, with the rate latched when a word is accepted.
module lcm_serial_writer #(
    parameter int WIDTH = 16
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic [4:0]       div_base,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic             busy,
    output logic             done,
    output logic             lcm_csn,
    output logic             lcm_scl,
    output logic             lcm_sda
);

    localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t           state;
    logic [4:0]       hc;
    logic [4:0]       div_base_q;
    logic [BCW-1:0]   bit_cnt;
    logic             phase_hi;
    logic [WIDTH-1:0] shift_q;
    logic             accept;
    logic             phase_end;

    assign accept    = wr_valid & wr_ready;
    assign phase_end = (hc == div_base_q);

    // Word and rate hold no control meaning, so they carry no reset.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            shift_q    <= wr_data;
            div_base_q <= div_base;
        end else if (state == S_SHIFT && phase_hi && phase_end && bit_cnt != '0) begin
            shift_q <= shift_q << 1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            hc       <= '0;
            bit_cnt  <= '0;
            phase_hi <= 1'b0;
            wr_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            lcm_csn  <= 1'b1;
            lcm_scl  <= 1'b1;
            lcm_sda  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                hc <= '0;
            end else begin
                hc <= phase_end ? 5'd0 : hc + 5'd1;
            end
            case (state)
                S_IDLE: begin
                    if (wr_valid) begin
                        state    <= S_SETUP;
                        bit_cnt  <= BCW'(WIDTH - 1);
                        wr_ready <= 1'b0;
                        busy     <= 1'b1;
                        lcm_csn  <= 1'b0;
                        lcm_scl  <= 1'b1;
                        lcm_sda  <= wr_data[WIDTH-1];
                    end
                end
                S_SETUP: begin
                    if (phase_end) begin
                        state    <= S_SHIFT;
                        phase_hi <= 1'b0;
                        lcm_scl  <= 1'b0;
                        lcm_sda  <= shift_q[WIDTH-1];
                    end
                end
                S_SHIFT: begin
                    if (phase_end) begin
                        if (!phase_hi) begin
                            phase_hi <= 1'b1;
                            lcm_scl  <= 1'b1;
                        end else if (bit_cnt == '0) begin
                            state <= S_HOLD;
                        end else begin
                            // Next bit is presented together with the falling SCL edge.
                            bit_cnt  <= bit_cnt - 1'b1;
                            phase_hi <= 1'b0;
                            lcm_scl  <= 1'b0;
                            lcm_sda  <= shift_q[WIDTH-2];
                        end
                    end
                end
                S_HOLD: begin
                    if (phase_end) begin
                        state   <= S_GAP;
                        lcm_csn <= 1'b1;
                        lcm_sda <= 1'b0;
                        done    <= (div_base_q == 5'd0);
                    end
                end
                S_GAP: begin
                    // done is registered, so it is raised one cycle ahead of the last GAP cycle.
                    if (phase_end) begin
                        state    <= S_IDLE;
                        wr_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else if (hc == div_base_q - 5'd1) begin
                        done <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcm_serial_writer.sv
// Scoreboard bench for lcm_serial_writer: stimulus queues expected words/rates, a bus monitor
// decodes each transfer and checks word, timing and handshake when done pulses.
module tb_lcm_serial_writer;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic [4:0]  div_base;
    logic [15:0] wr_data;
    logic        wr_valid;
    logic        wr_ready, busy, done, lcm_csn, lcm_scl, lcm_sda;

    lcm_serial_writer #(.WIDTH(16)) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .div_base (div_base),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .busy     (busy),
        .done     (done),
        .lcm_csn  (lcm_csn),
        .lcm_scl  (lcm_scl),
        .lcm_sda  (lcm_sda)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] word;
        int          h;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    // Bus monitor
    logic        mon_active = 1'b0;
    logic        chk_ready_next = 1'b0;
    int          acc_cyc, cur_h, edges, csn_low, low_run, high_run;
    int          phase_err, sda_err, ctl_err;
    int          last_done_cyc = -1;
    logic [15:0] cap;
    logic        prev_scl, prev_sda, prev_csn;
    exp_t        e;

    always @(negedge clk_in) begin
        if (!rst_n) begin
            mon_active     = 1'b0;
            chk_ready_next = 1'b0;
        end else begin
            if (chk_ready_next) begin
                chk("ready_after_done", int'({wr_ready, busy, done}), 3'b100);
                chk_ready_next = 1'b0;
            end
            if (mon_active && cyc > acc_cyc) begin
                if (wr_ready !== 1'b0 || busy !== 1'b1) ctl_err++;
                if (!lcm_csn) csn_low++;
                if (lcm_scl && !prev_scl) begin
                    if (!lcm_csn) begin
                        cap = {cap[14:0], lcm_sda};
                        edges++;
                    end
                    if (low_run != cur_h) phase_err++;
                end
                if (!lcm_scl && prev_scl && high_run != cur_h) phase_err++;
                if (lcm_scl) high_run = prev_scl ? high_run + 1 : 1;
                else         low_run  = prev_scl ? 1 : low_run + 1;
                if (!lcm_csn && !prev_csn && lcm_scl && prev_scl && lcm_sda != prev_sda) sda_err++;
                if (done) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("word", int'(cap), int'(e.word));
                        chk("scl_edges", edges, 16);
                        chk("csn_low_cycles", csn_low, 34 * e.h);
                        chk("done_latency", cyc - acc_cyc, 35 * e.h);
                        chk("phase_len_errs", phase_err, 0);
                        chk("sda_stable_errs", sda_err, 0);
                        chk("ready_busy_errs", ctl_err, 0);
                    end
                    mon_active     = 1'b0;
                    chk_ready_next = 1'b1;
                    last_done_cyc  = cyc;
                end
                prev_scl = lcm_scl;
                prev_sda = lcm_sda;
                prev_csn = lcm_csn;
            end else if (done) begin
                chk("spurious_done", 1, 0);
            end
            if (wr_valid && wr_ready) begin
                mon_active = 1'b1;
                acc_cyc    = cyc;
                cur_h      = (sb.size() != 0) ? sb[0].h : 0;
                edges = 0; cap = '0; csn_low = 0; low_run = 0; high_run = 0;
                phase_err = 0; sda_err = 0; ctl_err = 0;
                prev_scl = 1'b1; prev_csn = 1'b1; prev_sda = 1'b0;
            end
        end
    end

    // Stimulus
    task automatic wait_accept(output int acc);
        int n = 0;
        @(negedge clk_in);
        while (!(wr_ready && wr_valid) && n < 3000) begin
            n++;
            @(negedge clk_in);
        end
        if (!(wr_ready && wr_valid)) chk("accept_timeout", 0, 1);
        acc = cyc;
    endtask

    task automatic send(input logic [15:0] word, input logic [4:0] db, output int acc);
        @(posedge clk_in); #2;
        wr_data  = word;
        div_base = db;
        wr_valid = 1'b1;
        sb.push_back('{word, int'(db) + 1});
        wait_accept(acc);
        @(posedge clk_in); #2;
        wr_valid = 1'b0;
        wr_data  = 16'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk_in);
        while (!(sb.size() == 0 && wr_ready) && n < 5000) begin
            n++;
            @(negedge clk_in);
        end
        if (!(sb.size() == 0 && wr_ready)) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        int acc, acc2;
        rst_n = 1'b0; wr_valid = 1'b0; div_base = 5'd0; wr_data = 16'h0;
        repeat (2) @(negedge clk_in);
        chk("rst_wr_ready", int'(wr_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_csn", int'(lcm_csn), 1);
        chk("rst_scl", int'(lcm_scl), 1);
        chk("rst_sda", int'(lcm_sda), 0);
        @(posedge clk_in); #2;
        rst_n = 1'b1;

        // H=1 basic word
        send(16'hA55A, 5'd0, acc);
        wait_idle();

        // H=5, all ones
        send(16'hFFFF, 5'd4, acc);
        wait_idle();

        // wr_valid held high across two words
        @(posedge clk_in); #2;
        sb.push_back('{16'h0001, 2});
        sb.push_back('{16'h8000, 2});
        wr_data = 16'h0001; div_base = 5'd1; wr_valid = 1'b1;
        wait_accept(acc);
        @(posedge clk_in); #2;
        wr_data = 16'h8000;
        wait_accept(acc2);
        chk("b2b_accept_cycle", acc2, last_done_cyc + 1);
        @(posedge clk_in); #2;
        wr_valid = 1'b0;
        wait_idle();

        // div_base changed mid-SHIFT only affects the next word
        send(16'hC3C3, 5'd2, acc);
        repeat (20) @(posedge clk_in);
        #2 div_base = 5'd9;
        wait_idle();
        send(16'h3C96, 5'd9, acc);
        wait_idle();

        // wr_valid pulse while busy is ignored
        send(16'h0F0F, 5'd1, acc);
        repeat (10) @(posedge clk_in);
        #2 wr_valid = 1'b1; wr_data = 16'hFFFF;
        @(posedge clk_in); #2 wr_valid = 1'b0;
        wait_idle();

        // Reset during bit 7 (H=2: bit 7 high phase starts at A+37)
        send(16'hBEEF, 5'd1, acc);
        while (cyc < acc + 36) @(negedge clk_in);
        @(posedge clk_in); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_csn", int'(lcm_csn), 1);
        chk("midrst_scl", int'(lcm_scl), 1);
        chk("midrst_sda", int'(lcm_sda), 0);
        chk("midrst_wr_ready", int'(wr_ready), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        sb.delete();
        repeat (3) @(negedge clk_in);
        chk("midrst_done_held", int'(done), 0);
        @(posedge clk_in); #2;
        rst_n = 1'b1;
        send(16'h1234, 5'd1, acc);
        wait_idle();

        repeat (3) @(negedge clk_in);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
